// File: rtl/text_pkg.sv
// Shared constants, character-cell layout and colour helpers for the text-mode
// glyph fetch path (80x30 cells of 8x16 pixels).
package text_pkg;

    localparam int COLS        = 80;
    localparam int ROWS        = 30;
    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;
    localparam int VRAM_WORDS  = 1200;
    localparam int VRAM_AW     = $clog2(VRAM_WORDS);
    localparam int PAL_ENTRIES = 16;
    localparam int COLOR_W     = 12;
    localparam int PAL_W       = PAL_ENTRIES * COLOR_W;

    // One 16-bit character cell as stored in VRAM (two per 32-bit word).
    typedef struct packed {
        logic       inv;
        logic [6:0] code;
        logic [3:0] fg;
        logic [3:0] bkg;
    } char_attr_t;

    function automatic logic [31:0] pack_cmd(input logic [COLOR_W-1:0] fg,
                                             input logic [COLOR_W-1:0] bkg);
        return {7'd0, fg, bkg, 1'b0};
    endfunction

    // Entry n lives at [12n+11:12n]; 12n is formed as 8n+4n to keep the select index narrow.
    function automatic logic [COLOR_W-1:0] pal_color(input logic [PAL_W-1:0] pal,
                                                     input logic [3:0]       n);
        logic [7:0] base;
        base = 8'({n, 3'b000}) + 8'({n, 2'b00});
        return pal[base +: COLOR_W];
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with asynchronous clear; keeps side-band signals
// aligned with the glyph fetch pipeline.
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            // NOTE: every tap is cleared, not just the output, so an aborted frame leaves no samples to drain out after release.
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments let each tap take its neighbour's old value in one edge; blocking would collapse the chain.
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/text_glyph_fetch.sv
// Pixel-rate fetch: raster position -> VRAM cell -> font ROM row + palette colours,
// with DrawX/vde/sync delayed to stay aligned with the fetched data.
module text_glyph_fetch
    import text_pkg::*;
#(
    parameter int VRAM_LAT = 1,
    parameter int FONT_LAT = 1
) (
    input  logic         pixel_clk,
    input  logic         reset,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    input  logic         vde_i,
    input  logic         hsync_i,
    input  logic         vsync_i,
    output logic [10:0]  vram_addr_o,
    input  logic [31:0]  vram_rdata_i,
    output logic [10:0]  font_addr_o,
    input  logic [7:0]   font_data_i,
    input  logic [191:0] palette_i,
    output logic [9:0]   DrawX_o,
    output logic         vde_o,
    output logic         hsync_o,
    output logic         vsync_o,
    output logic [7:0]   font_line_o,
    output logic         inv_bit_o,
    output logic [31:0]  cmd_o
);

    localparam int LATENCY = 3 + VRAM_LAT + FONT_LAT;

    logic [6:0]  col;
    logic [4:0]  row;
    logic [11:0] idx;
    logic        in_range;

    always_comb begin
        col      = 7'(DrawX >> $clog2(GLYPH_W));
        row      = 5'(DrawY >> $clog2(GLYPH_H));
        idx      = (12'(row) << 6) + (12'(row) << 4) + 12'(col);
        in_range = vde_i && (int'(col) < COLS) && (int'(row) < ROWS);
    end

    // Stage 1: VRAM address. Held while out of range so it never leaves 0..1199.
    logic       s1_sel;
    logic [3:0] s1_row;
    logic       s1_rng;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            vram_addr_o <= '0;
            s1_sel      <= 1'b0;
            s1_row      <= '0;
            s1_rng      <= 1'b0;
        end else begin
            if (in_range) vram_addr_o <= idx[VRAM_AW:1];
            s1_sel <= idx[0];
            s1_row <= DrawY[3:0];
            s1_rng <= in_range;
        end
    end

    logic       s2_sel;
    logic [3:0] s2_row;
    logic       s2_rng;

    sig_delay #(.WIDTH(6), .DEPTH(VRAM_LAT)) u_vram_wait (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .d         ({s1_sel, s1_row, s1_rng}),
        .q         ({s2_sel, s2_row, s2_rng})
    );

    char_attr_t s2_char;

    always_comb begin
        // NOTE: default first, then override, so no path leaves s2_char unassigned and no latch is inferred.
        s2_char = vram_rdata_i[15:0];
        if (s2_sel) s2_char = vram_rdata_i[31:16];
    end

    // Stage 3: font address plus attributes; palette_i is sampled on this edge.
    logic               s3_inv;
    logic [COLOR_W-1:0] s3_fg;
    logic [COLOR_W-1:0] s3_bkg;
    logic               s3_rng;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            font_addr_o <= '0;
            s3_inv      <= 1'b0;
            s3_fg       <= '0;
            s3_bkg      <= '0;
            s3_rng      <= 1'b0;
        end else begin
            if (s2_rng) font_addr_o <= {s2_char.code, s2_row};
            s3_inv <= s2_rng & s2_char.inv;
            s3_fg  <= s2_rng ? pal_color(palette_i, s2_char.fg)  : '0;
            s3_bkg <= s2_rng ? pal_color(palette_i, s2_char.bkg) : '0;
            s3_rng <= s2_rng;
        end
    end

    logic               s4_inv;
    logic [COLOR_W-1:0] s4_fg;
    logic [COLOR_W-1:0] s4_bkg;
    logic               s4_rng;

    sig_delay #(.WIDTH(2 * COLOR_W + 2), .DEPTH(FONT_LAT)) u_font_wait (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .d         ({s3_inv, s3_fg, s3_bkg, s3_rng}),
        .q         ({s4_inv, s4_fg, s4_bkg, s4_rng})
    );

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            font_line_o <= '0;
            inv_bit_o   <= 1'b0;
            cmd_o       <= '0;
        end else begin
            font_line_o <= s4_rng ? font_data_i : '0;
            inv_bit_o   <= s4_inv;
            cmd_o       <= pack_cmd(s4_fg, s4_bkg);
        end
    end

    // Side-band path matches the data path depth exactly, whatever the latencies.
    sig_delay #(.WIDTH(13), .DEPTH(LATENCY)) u_sync_delay (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .d         ({DrawX, vde_i, hsync_i, vsync_i}),
        .q         ({DrawX_o, vde_o, hsync_o, vsync_o})
    );

endmodule

// File: tb/tb_text_glyph_fetch.sv
// Directed and random-stream bench for text_glyph_fetch with behavioural VRAM,
// font ROM and a per-pixel reference model checked five clocks later.
module tb_text_glyph_fetch;

    logic         pixel_clk = 1'b0;
    logic         reset     = 1'b1;
    logic [9:0]   DrawX     = '0;
    logic [9:0]   DrawY     = '0;
    logic         vde_i     = 1'b0;
    logic         hsync_i   = 1'b0;
    logic         vsync_i   = 1'b0;
    logic [10:0]  vram_addr_o;
    logic [31:0]  vram_rdata_i;
    logic [10:0]  font_addr_o;
    logic [7:0]   font_data_i;
    logic [191:0] palette_i;
    logic [9:0]   DrawX_o;
    logic         vde_o;
    logic         hsync_o;
    logic         vsync_o;
    logic [7:0]   font_line_o;
    logic         inv_bit_o;
    logic [31:0]  cmd_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] vram [0:1199];

    typedef struct packed {
        logic [9:0]  x;
        logic        vde;
        logic        hs;
        logic        vs;
        logic [7:0]  font;
        logic        inv;
        logic [31:0] cmd;
    } exp_t;

    exp_t exp_q[$];

    text_glyph_fetch dut (
        .pixel_clk    (pixel_clk),
        .reset        (reset),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .vde_i        (vde_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .vram_addr_o  (vram_addr_o),
        .vram_rdata_i (vram_rdata_i),
        .font_addr_o  (font_addr_o),
        .font_data_i  (font_data_i),
        .palette_i    (palette_i),
        .DrawX_o      (DrawX_o),
        .vde_o        (vde_o),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .font_line_o  (font_line_o),
        .inv_bit_o    (inv_bit_o),
        .cmd_o        (cmd_o)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        return a[7:0] ^ {a[10:4], 1'b1};
    endfunction

    // One-clock synchronous VRAM and font ROM.
    always @(posedge pixel_clk) begin
        vram_rdata_i <= vram[vram_addr_o];
        font_data_i  <= font_fn(font_addr_o);
    end

    function automatic logic [11:0] pal(input int n);
        return 12'(palette_i >> (12 * n));
    endfunction

    function automatic exp_t model(input logic [9:0] x, input logic [9:0] y,
                                   input logic v, input logic hs, input logic vs);
        exp_t        e;
        int          col, row, idx;
        logic [31:0] w;
        logic [15:0] h;
        e     = '0;
        e.x   = x;
        e.vde = v;
        e.hs  = hs;
        e.vs  = vs;
        col   = int'(x) / 8;
        row   = (int'(y) % 512) / 16;
        if (v && col < 80 && row < 30) begin
            idx    = row * 80 + col;
            w      = vram[11'(idx / 2)];
            h      = (idx % 2 == 1) ? w[31:16] : w[15:0];
            e.font = font_fn({h[14:8], y[3:0]});
            e.inv  = h[15];
            e.cmd  = {7'd0, pal(int'(h[7:4])), pal(int'(h[3:0])), 1'b0};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Present one pixel, advance one clock, and compare against the pixel five clocks back.
    task automatic drive(input logic [9:0] x, input logic [9:0] y,
                         input logic v, input logic hs, input logic vs);
        exp_t e;
        DrawX   = x;
        DrawY   = y;
        vde_i   = v;
        hsync_i = hs;
        vsync_i = vs;
        exp_q.push_back(model(x, y, v, hs, vs));
        @(posedge pixel_clk);
        #1;
        e = exp_q.pop_front();
        check("DrawX_o",     32'(DrawX_o),     32'(e.x));
        check("vde_o",       32'(vde_o),       32'(e.vde));
        check("hsync_o",     32'(hsync_o),     32'(e.hs));
        check("vsync_o",     32'(vsync_o),     32'(e.vs));
        check("font_line_o", 32'(font_line_o), 32'(e.font));
        check("inv_bit_o",   32'(inv_bit_o),   32'(e.inv));
        check("cmd_o",       cmd_o,            e.cmd);
    endtask

    task automatic hold(input logic [9:0] x, input logic [9:0] y, input logic v, input int n);
        repeat (n) drive(x, y, v, 1'b0, 1'b0);
    endtask

    task automatic refill_expect();
        exp_q.delete();
        repeat (4) exp_q.push_back('0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vram_addr_o"}, 32'(vram_addr_o), 32'd0);
        check({tag, " font_addr_o"}, 32'(font_addr_o), 32'd0);
        check({tag, " DrawX_o"},     32'(DrawX_o),     32'd0);
        check({tag, " vde_o"},       32'(vde_o),       32'd0);
        check({tag, " hsync_o"},     32'(hsync_o),     32'd0);
        check({tag, " vsync_o"},     32'(vsync_o),     32'd0);
        check({tag, " font_line_o"}, 32'(font_line_o), 32'd0);
        check({tag, " inv_bit_o"},   32'(inv_bit_o),   32'd0);
        check({tag, " cmd_o"},       cmd_o,            32'd0);
    endtask

    task automatic blank_checks(input string tag);
        check({tag, " font_line_o"}, 32'(font_line_o), 32'd0);
        check({tag, " inv_bit_o"},   32'(inv_bit_o),   32'd0);
        check({tag, " cmd_o"},       cmd_o,            32'd0);
        check({tag, " vram_addr_o"}, 32'(vram_addr_o), 32'd1199);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1200; i++) vram[i] = $urandom;
        vram[0]    = 32'hC212_413C;
        vram[1199] = {16'h9D5B, 16'($urandom)};
        for (int n = 0; n < 16; n++) palette_i[n*12 +: 12] = 12'($urandom);
        palette_i[1*12  +: 12] = 12'h0A5;
        palette_i[2*12  +: 12] = 12'h3C0;
        palette_i[3*12  +: 12] = 12'hF00;
        palette_i[5*12  +: 12] = 12'h5A5;
        palette_i[11*12 +: 12] = 12'hB0B;
        palette_i[12*12 +: 12] = 12'h00F;

        // Held in reset across several edges: everything stays cleared.
        repeat (3) @(posedge pixel_clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        refill_expect();

        // Cell (0,0), even half.
        hold(10'd0, 10'd2, 1'b1, 5);
        check("c00 vram_addr_o", 32'(vram_addr_o), 32'd0);
        check("c00 font_addr_o", 32'(font_addr_o), 32'h412);
        check("c00 inv_bit_o",   32'(inv_bit_o),   32'd0);
        check("c00 cmd_o",       cmd_o,            32'h01E0_001E);
        for (int x = 1; x < 8; x++) begin
            drive(10'(x), 10'd2, 1'b1, 1'b0, 1'b0);
            check("c00 sweep cmd_o", cmd_o, 32'h01E0_001E);
        end

        // Cell (1,0), odd half, inverse.
        hold(10'd8, 10'd0, 1'b1, 5);
        check("odd vram_addr_o", 32'(vram_addr_o), 32'd0);
        check("odd font_addr_o", 32'(font_addr_o), 32'h420);
        check("odd inv_bit_o",   32'(inv_bit_o),   32'd1);
        check("odd cmd_o",       cmd_o,            32'h0014_A780);

        // Last cell (79,29): idx 2399 -> word 1199, upper half.
        hold(10'd639, 10'd479, 1'b1, 5);
        check("last vram_addr_o", 32'(vram_addr_o), 32'd1199);
        check("last font_addr_o", 32'(font_addr_o), 32'h1DF);
        check("last inv_bit_o",   32'(inv_bit_o),   32'd1);
        check("last cmd_o",       cmd_o,            32'h00B4_B616);

        // Blanking cases: vde low, row 30, column 87.
        hold(10'd100, 10'd100, 1'b0, 5);
        blank_checks("blank vde0");
        hold(10'd20, 10'd480, 1'b1, 5);
        blank_checks("blank row30");
        hold(10'd700, 10'd10, 1'b1, 5);
        blank_checks("blank col87");

        // Random stream with an asynchronous reset dropped in mid-frame.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                #3 reset = 1'b1;
                #1;
                check_all_zero("async");
                @(posedge pixel_clk);
                #1;
                check_all_zero("in reset");
                reset = 1'b0;
                refill_expect();
                for (int k = 0; k < 6; k++) begin
                    drive(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
                          1'b1, 1'b0, 1'b0);
                    check("refill vde_o", 32'(vde_o), 32'(k >= 4));
                end
            end
            drive(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
